// File: rtl/line_raster_if.sv
// line_raster_if: request/pixel bus for the line rasterizer.
//   master : requester/sink side. Drives start, x0..y1 and px_ready, and sees
//            busy, done and the pixel stream.
//   slave  : rasterizer side. Sees the request and px_ready, and drives busy,
//            px_x, px_y, px_valid, px_last and done.
// COORD_W must match the COORD_W of the line_raster it is bound to.
interface line_raster_if #(
  parameter int COORD_W = 10
);
  logic               start;
  logic [COORD_W-1:0] x0, y0, x1, y1;
  logic               busy;
  logic [COORD_W-1:0] px_x, px_y;
  logic               px_valid;
  logic               px_ready;
  logic               px_last;
  logic               done;

  modport master (
    output start, x0, y0, x1, y1, px_ready,
    input  busy, px_x, px_y, px_valid, px_last, done
  );

  modport slave (
    input  start, x0, y0, x1, y1, px_ready,
    output busy, px_x, px_y, px_valid, px_last, done
  );
endinterface

// File: rtl/line_raster.sv
// line_raster: Bresenham line rasterizer. It emits one pixel per accepted
// handshake, from (x0,y0) to (x1,y1), in any octant.
//   clk, n_rst : clock (rising edge) and asynchronous active-low reset
//   bus        : line_raster_if.slave. It carries the start/endpoint request,
//                busy/done status and the px_* valid/ready pixel stream.
// Optional feature: define LINE_RASTER_CLIP_EN to suppress pixels outside
// SCREEN_W x SCREEN_H. Suppressed pixels are stepped past in one cycle
// without waiting for px_ready.
module line_raster #(
  parameter int COORD_W  = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input logic          clk,
  input logic          n_rst,
  line_raster_if.slave bus
);
  localparam int EW = COORD_W + 2;

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_e;

  if (SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_screen
    $error("line_raster: SCREEN_W/SCREEN_H must be positive");
  end

  state_e                state_q, state_d;
  logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;   // current pixel; holds (x0,y0) through SETUP
  logic [COORD_W-1:0]    x1_q, x1_d, y1_q, y1_d;
  logic signed [EW-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                  sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  logic [COORD_W-1:0]    adx, ady;
  logic signed [EW-1:0]  e2;
  logic                  at_end, on_screen, px_valid, retire, step_x, step_y;

`ifdef LINE_RASTER_CLIP_EN
  localparam logic [COORD_W:0] SW = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] SH = (COORD_W+1)'(SCREEN_H);
  assign on_screen = ({1'b0, x_q} < SW) && ({1'b0, y_q} < SH);
`else
  assign on_screen = 1'b1;
`endif

  assign at_end   = (x_q == x1_q) && (y_q == y1_q);
  assign px_valid = (state_q == RUN) && on_screen;
  // Off-screen pixels never wait on the sink.
  assign retire   = (state_q == RUN) && (on_screen ? bus.px_ready : 1'b1);
  assign e2       = err_q <<< 1;
  assign step_x   = (e2 >= dy_q);
  assign step_y   = (e2 <= dx_q);
  assign adx      = (x1_q >= x_q) ? (x1_q - x_q) : (x_q - x1_q);
  assign ady      = (y1_q >= y_q) ? (y1_q - y_q) : (y_q - y1_q);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    case (state_q)
      IDLE: if (bus.start) begin
        x_d     = bus.x0;
        y_d     = bus.y0;
        x1_d    = bus.x1;
        y1_d    = bus.y1;
        state_d = SETUP;
      end
      SETUP: begin
        dx_d     = $signed({2'b00, adx});
        dy_d     = -$signed({2'b00, ady});
        err_d    = $signed({2'b00, adx}) - $signed({2'b00, ady});
        sx_neg_d = !(x_q < x1_q);
        sy_neg_d = !(y_q < y1_q);
        state_d  = RUN;
      end
      RUN: if (retire) begin
        if (at_end) begin
          state_d = DONE;
        end else begin
          // Both axis steps may fire in the same cycle (diagonal move).
          err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
          if (step_x) x_d = sx_neg_q ? x_q - 1'b1 : x_q + 1'b1;
          if (step_y) y_d = sy_neg_q ? y_q - 1'b1 : y_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.px_x     = x_q;
  assign bus.px_y     = y_q;
  assign bus.px_valid = px_valid;
  assign bus.px_last  = px_valid && at_end;
  assign bus.done     = (state_q == DONE);
endmodule
